// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared pipeline-control types and constants
package cpu_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;
  localparam int MEM_TIMEOUT_DEFAULT = 64;
  localparam int REG_W = 5;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (clear) count <= '0;
    else if (inc && count != '1) count <= count + W'(1);
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline
module pipe_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_wn,
  input  logic             mem_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             id_ex_enable,
  output logic             ex_mem_enable,
  output logic             mem_wb_enable,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             pc_redirect,
  output logic             mem_error,
  output logic [31:0]      stall_count
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  state_t state, state_n;
  logic [CW-1:0] wait_cnt, wait_cnt_n, wait_idx;
  logic err, load_use, waiting, normal, timeout, live;
  logic [31:0] stall_raw;
  assign live = !reset;
  assign load_use = ex_mem_read && ex_wn != '0 &&
                    (ex_wn == id_rs || (id_uses_rt && ex_wn == id_rt));
  // wait_idx is the 1-based number of the current not-ready cycle of this access
  always_comb begin
    waiting = !mem_ready && (state == MEM_WAIT || (state == RUN && mem_req));
    normal = state != HALT && !waiting;
    wait_idx = state == RUN ? CW'(1) : wait_cnt + CW'(1);
    timeout = waiting && wait_idx >= CW'(MEM_TIMEOUT);
    state_n = timeout ? HALT : waiting ? MEM_WAIT : state == HALT ? HALT : RUN;
    wait_cnt_n = waiting && !timeout ? wait_idx : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      wait_cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      wait_cnt <= wait_cnt_n;
      err <= err | timeout;
    end
  end
  assign pc_enable     = live && normal && (mem_taken || !load_use);
  assign if_id_enable  = pc_enable;
  assign id_ex_enable  = live && normal;
  assign ex_mem_enable = id_ex_enable;
  assign mem_wb_enable = id_ex_enable;
  assign pc_redirect   = live && normal && mem_taken;
  assign if_id_flush   = pc_redirect;
  assign ex_mem_flush  = pc_redirect;
  assign id_ex_flush   = live && normal && (mem_taken || load_use);
  assign mem_wb_flush  = live && waiting;
  assign mem_error     = live && err;
  assign stall_count   = live ? stall_raw : '0;
  sat_counter #(.W(32)) u_stall (
    .clk  (clk),
    .clear(reset),
    .inc  (!pc_enable),
    .count(stall_raw)
  );
endmodule
